// File: rtl/lut_config_loader.sv
// Streaming configuration loader for a column of LUT4 BELs: header, data words
// and an XOR checksum fill a shadow array that is committed to ConfigBits atomically.
module lut_config_loader #(
  parameter int unsigned NUM_BELS     = 8,
  parameter int unsigned NoConfigBits = 19
) (
  input  logic                                UserCLK,
  input  logic                                Reset,
  input  logic [31:0]                         cfg_data,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  output logic [NUM_BELS*NoConfigBits-1:0]    ConfigBits,
  output logic                                busy,
  output logic                                done,
  output logic                                error
);

  localparam int unsigned CW = NoConfigBits;
  localparam int unsigned PW = 5;
  localparam logic [3:0]  SYNC = 4'hA;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_COMMIT,
    S_ABORT
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   remaining;
  logic [CW-1:0]   checksum;
  logic [CW-1:0]   shadow [NUM_BELS];
  logic            ready_q;

  logic            accept_c;
  logic [PW-1:0]   hdr_start_c;
  logic [PW-1:0]   hdr_count_c;
  logic            hdr_ok_c;
  logic            hdr_take_c;
  logic            hdr_bad_c;
  logic            data_take_c;
  logic            sum_bad_c;
  logic            do_commit_c;
  logic            do_restore_c;
  logic            ready_nxt_c;
  logic            busy_nxt_c;
  logic            unused_bits;

  // Ready drops combinationally while Reset is held; otherwise it is a flop.
  assign cfg_ready = ready_q & ~Reset;
  assign accept_c  = cfg_valid & cfg_ready;

  // Header fields; count is encoded as count-1, so 4 bits cover 1..16 BELs.
  assign hdr_start_c = PW'(cfg_data[7:4]);
  assign hdr_count_c = PW'(cfg_data[3:0]) + PW'(1);
  assign hdr_ok_c    = (cfg_data[31:28] == SYNC) &&
                       ((6'(hdr_start_c) + 6'(hdr_count_c)) <= 6'(NUM_BELS));

  assign unused_bits = ^{cfg_data[27:8]};

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt    = state;
    hdr_take_c   = 1'b0;
    hdr_bad_c    = 1'b0;
    data_take_c  = 1'b0;
    sum_bad_c    = 1'b0;
    do_commit_c  = 1'b0;
    do_restore_c = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept_c) begin
          if (hdr_ok_c) begin
            hdr_take_c = 1'b1;
            state_nxt  = S_LOAD;
          end else begin
            hdr_bad_c = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept_c) begin
          data_take_c = 1'b1;
          if (remaining == PW'(1)) state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (accept_c) begin
          if (cfg_data[CW-1:0] == checksum) begin
            state_nxt = S_COMMIT;
          end else begin
            sum_bad_c = 1'b1;
            state_nxt = S_ABORT;
          end
        end
      end
      S_COMMIT: begin
        do_commit_c = 1'b1;
        state_nxt   = S_IDLE;
      end
      S_ABORT: begin
        do_restore_c = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    ready_nxt_c = (state_nxt == S_IDLE) || (state_nxt == S_LOAD) ||
                  (state_nxt == S_CHECK);
    busy_nxt_c  = (state_nxt != S_IDLE);
  end

  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Status outputs, pointer, counter and running checksum.
  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      ready_q   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      ptr       <= '0;
      remaining <= '0;
      checksum  <= '0;
    end else begin
      ready_q <= ready_nxt_c;
      busy    <= busy_nxt_c;
      done    <= do_commit_c;
      if (hdr_bad_c || sum_bad_c) error <= 1'b1;
      else if (hdr_take_c)        error <= 1'b0;
      if (hdr_take_c) begin
        ptr       <= hdr_start_c;
        remaining <= hdr_count_c;
        checksum  <= '0;
      end else if (data_take_c) begin
        ptr       <= ptr + PW'(1);
        remaining <= remaining - PW'(1);
        checksum  <= checksum ^ cfg_data[CW-1:0];
      end
    end
  end

  // Shadow array: written by data words, rolled back from the live config on abort.
  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      for (int unsigned k = 0; k < NUM_BELS; k++) shadow[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_BELS; k++) begin
        if (do_restore_c)
          shadow[k] <= ConfigBits[k*CW +: CW];
        else if (data_take_c && (ptr == PW'(k)))
          shadow[k] <= cfg_data[CW-1:0];
      end
    end
  end

  // Live configuration only changes on a commit.
  always_ff @(posedge UserCLK or posedge Reset) begin
    if (Reset) begin
      ConfigBits <= '0;
    end else if (do_commit_c) begin
      for (int unsigned k = 0; k < NUM_BELS; k++) ConfigBits[k*CW +: CW] <= shadow[k];
    end
  end

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench for lut_config_loader with hand-computed expected configuration.
module tb_lut_config_loader;

  localparam int unsigned NB = 8;
  localparam int unsigned CW = 19;

  logic                 UserCLK;
  logic                 Reset;
  logic [31:0]          cfg_data;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [NB*CW-1:0]     ConfigBits;
  logic                 busy;
  logic                 done;
  logic                 error;

  logic [NB*CW-1:0]     exp_cfg;
  int                   n_total;
  int                   n_pass;

  lut_config_loader #(.NUM_BELS(NB), .NoConfigBits(CW)) dut (
    .UserCLK    (UserCLK),
    .Reset      (Reset),
    .cfg_data   (cfg_data),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .ConfigBits (ConfigBits),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  // Present one word and hold it until the handshake completes.
  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    cfg_data  = d;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 10) begin
      tick();
      n++;
    end
    if (!cfg_ready) chk("ready_timeout", 160'(cfg_ready), 160'(1));
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    exp_cfg   = '0;
    Reset     = 1'b1;
    cfg_data  = '0;
    cfg_valid = 1'b0;
    tick();
    chk("rst_ready", 160'(cfg_ready), 160'(0));
    chk("rst_busy",  160'(busy),      160'(0));
    chk("rst_done",  160'(done),      160'(0));
    chk("rst_error", 160'(error),     160'(0));
    chk("rst_cfg",   160'(ConfigBits), 160'(0));
    Reset = 1'b0;
    #1;
    chk("post_rst_ready", 160'(cfg_ready), 160'(1));

    // Two-BEL frame at BEL 0.
    send(32'hA000_0001);
    chk("load_busy", 160'(busy), 160'(1));
    send(32'h0000_8001);
    send(32'h0001_0000);
    send(32'h0001_8001);
    chk("commit_ready", 160'(cfg_ready), 160'(0));
    chk("commit_done_early", 160'(done), 160'(0));
    chk("commit_cfg_old", 160'(ConfigBits), 160'(0));
    tick();
    exp_cfg[0*CW +: CW] = 19'h08001;
    exp_cfg[1*CW +: CW] = 19'h10000;
    chk("f1_done", 160'(done), 160'(1));
    chk("f1_cfg", 160'(ConfigBits), 160'(exp_cfg));
    chk("f1_error", 160'(error), 160'(0));
    tick();
    chk("f1_done_off", 160'(done), 160'(0));
    chk("f1_idle_busy", 160'(busy), 160'(0));

    // Out-of-range header: start 6, count 3.
    send(32'hA000_0062);
    chk("range_error", 160'(error), 160'(1));
    chk("range_busy", 160'(busy), 160'(0));
    chk("range_ready", 160'(cfg_ready), 160'(1));
    chk("range_cfg", 160'(ConfigBits), 160'(exp_cfg));

    // Bad checksum on BEL 3 aborts; a follow-up frame on BEL 4 must not leak it.
    send(32'hA000_0030);
    chk("ab_hdr_clears", 160'(error), 160'(0));
    send(32'h0007_FFFF);
    send(32'h0000_0000);
    chk("ab_error", 160'(error), 160'(1));
    chk("ab_ready", 160'(cfg_ready), 160'(0));
    tick();
    chk("ab_busy", 160'(busy), 160'(0));
    chk("ab_done", 160'(done), 160'(0));
    chk("ab_cfg", 160'(ConfigBits), 160'(exp_cfg));
    send(32'hA000_0040);
    chk("ab_next_clears", 160'(error), 160'(0));
    send(32'hFFFA_A5A5);
    send(32'hABC2_A5A5);
    tick();
    exp_cfg[4*CW +: CW] = 19'h2A5A5;
    chk("ab_next_done", 160'(done), 160'(1));
    chk("ab_bel3_kept", 160'(ConfigBits[3*CW +: CW]), 160'(0));
    chk("ab_next_cfg", 160'(ConfigBits), 160'(exp_cfg));

    // Frame ending at the top BEL; a data word looks like a header.
    send(32'hA000_0052);
    send(32'hA000_0001);
    send(32'h0004_0000);
    send(32'h0000_0F0F);
    cfg_data  = 32'h0004_0F0E;
    cfg_valid = 1'b1;
    tick();
    chk("hold_ready_low", 160'(cfg_ready), 160'(0));
    cfg_data = 32'hA000_0070;
    tick();
    exp_cfg[5*CW +: CW] = 19'h00001;
    exp_cfg[6*CW +: CW] = 19'h40000;
    exp_cfg[7*CW +: CW] = 19'h00F0F;
    chk("hold_done", 160'(done), 160'(1));
    chk("hold_ready_back", 160'(cfg_ready), 160'(1));
    chk("hold_cfg", 160'(ConfigBits), 160'(exp_cfg));
    tick();
    cfg_valid = 1'b0;
    chk("hold_hdr_taken", 160'(busy), 160'(1));
    send(32'h0000_0123);
    send(32'h0000_0123);
    tick();
    exp_cfg[7*CW +: CW] = 19'h00123;
    chk("hold_f2_cfg", 160'(ConfigBits), 160'(exp_cfg));

    // Reset in the middle of a four-word frame.
    send(32'hA000_0003);
    send(32'h0001_1111);
    #1 Reset = 1'b1;
    #1;
    exp_cfg = '0;
    chk("mid_rst_cfg", 160'(ConfigBits), 160'(0));
    chk("mid_rst_busy", 160'(busy), 160'(0));
    chk("mid_rst_ready", 160'(cfg_ready), 160'(0));
    tick();
    Reset = 1'b0;
    #1;
    chk("mid_rst_ready_back", 160'(cfg_ready), 160'(1));
    send(32'hA000_0003);
    send(32'h0000_0001);
    send(32'h0000_0002);
    send(32'h0000_0004);
    send(32'h0000_0008);
    send(32'h0000_000F);
    tick();
    exp_cfg[0*CW +: CW] = 19'h1;
    exp_cfg[1*CW +: CW] = 19'h2;
    exp_cfg[2*CW +: CW] = 19'h4;
    exp_cfg[3*CW +: CW] = 19'h8;
    chk("rst_reload_cfg", 160'(ConfigBits), 160'(exp_cfg));
    chk("rst_reload_error", 160'(error), 160'(0));

    // Gapped load into BELs 4..7 with valid toggling every cycle.
    send(32'hA000_0043);
    tick();
    send(32'h0000_0100);
    tick();
    chk("gap_busy", 160'(busy), 160'(1));
    send(32'h0000_0200);
    tick();
    send(32'h0000_0300);
    tick();
    send(32'h0000_0400);
    tick();
    chk("gap_no_commit", 160'(ConfigBits), 160'(exp_cfg));
    send(32'h0000_0400);
    tick();
    exp_cfg[4*CW +: CW] = 19'h100;
    exp_cfg[5*CW +: CW] = 19'h200;
    exp_cfg[6*CW +: CW] = 19'h300;
    exp_cfg[7*CW +: CW] = 19'h400;
    chk("gap_done", 160'(done), 160'(1));
    chk("gap_cfg", 160'(ConfigBits), 160'(exp_cfg));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lut_config_loader.md
LUT_CONFIG_LOADER -- requirements
Module: lut_config_loader

Interface
REQ-001 SHALL have parameter NUM_BELS, default 8, giving the number of LUT4 BELs configured (legal range 1..16).
REQ-002 SHALL have parameter NoConfigBits, default 19, giving the config bits per BEL; only 19 is supported.
REQ-003 SHALL have port UserCLK, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port cfg_data, input, 32, the configuration stream word.
REQ-006 SHALL have port cfg_valid, input, 1, marking cfg_data valid.
REQ-007 SHALL have port cfg_ready, output, 1, marking that the block can accept a word; a word is accepted when cfg_valid and cfg_ready are both 1 on a rising edge.
REQ-008 SHALL have port ConfigBits, output, NUM_BELS*19, the active config; BEL k occupies bits [19k+18:19k], with bit layout INIT[15:0], FF=16, IOmux=17, SET_NORESET=18.
REQ-009 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse on commit.
REQ-011 SHALL have port error, output, 1, a sticky frame-error flag.

Function
REQ-012 SHALL implement states IDLE, LOAD, CHECK, COMMIT and ABORT, plus a shadow register array of NUM_BELS x 19 bits.
REQ-013 SHALL drive cfg_ready=1 in IDLE, LOAD and CHECK, and cfg_ready=0 in COMMIT, ABORT and while Reset=1.
REQ-014 SHALL drive busy=1 in LOAD, CHECK, COMMIT and ABORT, and busy=0 in IDLE.
REQ-015 SHALL decode a header word accepted in IDLE as: sync=[31:28], start=[7:4], count-1=[3:0]; bits [27:8] are ignored.
REQ-016 SHALL treat a header as well-formed when sync==4'hA and start+count<=NUM_BELS; it then clears error, loads ptr=start and remaining=count, clears the running checksum, and goes to LOAD.
REQ-017 SHALL discard a malformed header, set error=1 and remain in IDLE.
REQ-018 SHALL, for each word accepted in LOAD: write shadow[ptr]<=cfg_data[18:0], XOR cfg_data[18:0] into the checksum, increment ptr and decrement remaining; the word that makes remaining 0 moves the FSM to CHECK.
REQ-019 SHALL ignore cfg_data[31:19] of data words; a data word equal to a sync pattern is still treated as data.
REQ-020 SHALL, on the word accepted in CHECK: go to COMMIT if cfg_data[18:0] equals the checksum, else go to ABORT and set error=1.
REQ-021 SHALL, in COMMIT (one cycle): copy all shadow entries to ConfigBits, then return to IDLE.
REQ-022 SHALL pulse done=1 for exactly the first cycle in which ConfigBits shows the new values, i.e. two rising edges after the checksum handshake.
REQ-023 SHALL, in ABORT (one cycle): restore shadow from ConfigBits, leave ConfigBits unchanged, and return to IDLE.
REQ-024 SHALL change ConfigBits only in COMMIT or on reset; BELs outside [start, start+count-1] keep their previous values after a commit.
REQ-025 SHALL hold all state while cfg_valid=0 in any state; there is no timeout.
REQ-026 SHALL count ptr and remaining in 5 bits, with no wrap-around possible after range validation.

Reset
REQ-027 SHALL, while Reset=1 (asynchronously, including mid-frame): set state=IDLE, ConfigBits=0, shadow=0, ptr/remaining/checksum=0, busy=0, done=0 and error=0.
REQ-028 SHALL, after Reset deasserts, drive cfg_ready=1 on the first cycle and discard any partially loaded frame.

Verification
REQ-029 SHALL cover: header 0xA0000001 (start 0, count 2), data 0x00008001 and 0x00010000, checksum 0x00018001 -> ConfigBits[18:0]=0x08001, [37:19]=0x10000, done pulses once, error=0.
REQ-030 SHALL cover: header 0xA0000062 (start 6, count 3, NUM_BELS=8) -> error=1, state IDLE, cfg_ready=1, ConfigBits unchanged.
REQ-031 SHALL cover: header 0xA0000030, data 0x0007FFFF, checksum 0x00000000 -> ABORT, error=1, ConfigBits[75:57] unchanged, and a following valid frame then clears error.
REQ-032 SHALL cover: after a valid checksum handshake -> cfg_ready=0 for exactly 1 cycle, and a word held on cfg_valid is accepted the next cycle as a header.
REQ-033 SHALL cover: Reset asserted after the first of 4 data words -> ConfigBits=0 and busy=0 immediately; a new frame then loads correctly.
REQ-034 SHALL cover: cfg_valid toggled 1/0 every cycle during LOAD -> final ConfigBits are identical to those of a gap-free load.
